// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter that shares the register bank's single write port among
// three writeback requesters and drives the bank from a registered output stage.
`timescale 1ns/1ps

module reg_wr_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int NREQ   = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        hold,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*ADDR_W-1:0]      req_addr,
  input  logic [NREQ*DATA_W-1:0]      req_data,
  output logic [NREQ-1:0]             req_ready,
  output logic                        reg_write,
  output logic [ADDR_W-1:0]           rd_addr,
  output logic [DATA_W-1:0]           write_data,
  output logic [(1<<ADDR_W)-1:0]      pending_mask,
  output logic [1:0]                  last_grant,
  output logic [15:0]                 wr_count,
  output logic [7:0]                  drop_count
);

  // rst_n is an active-high asynchronous reset despite its name.
  localparam int NREG = 1 << ADDR_W;

  logic [1:0]        ptr_r;
  logic              grant_vld_s;
  logic [1:0]        grant_idx_s;
  logic              xfer_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              sel_nonzero_s;

  // Search from `first` upward (mod 3); result is {found, index}.
  function automatic logic [2:0] rr_pick(input logic [2:0] v, input logic [1:0] first);
    logic [1:0] i0;
    logic [1:0] i1;
    logic [1:0] i2;
    case (first)
      2'd1: begin i0 = 2'd1; i1 = 2'd2; i2 = 2'd0; end
      2'd2: begin i0 = 2'd2; i1 = 2'd0; i2 = 2'd1; end
      default: begin i0 = 2'd0; i1 = 2'd1; i2 = 2'd2; end
    endcase
    if (v[i0]) begin
      rr_pick = {1'b1, i0};
    end else if (v[i1]) begin
      rr_pick = {1'b1, i1};
    end else if (v[i2]) begin
      rr_pick = {1'b1, i2};
    end else begin
      rr_pick = 3'b000;
    end
  endfunction

  function automatic logic [NREG-1:0] addr_onehot(input logic [ADDR_W-1:0] a);
    addr_onehot = {{(NREG-1){1'b0}}, 1'b1} << a;
  endfunction

  function automatic logic [1:0] ptr_after(input logic [1:0] idx);
    case (idx)
      2'd0:    ptr_after = 2'd1;
      2'd1:    ptr_after = 2'd2;
      default: ptr_after = 2'd0;
    endcase
  endfunction

  // Combinational grant selection; hold masks every grant.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = 2'd0;
    req_ready   = {NREQ{1'b0}};
    {grant_vld_s, grant_idx_s} = rr_pick(req_valid[2:0], ptr_r);
    if (grant_vld_s && !hold) begin
      req_ready = 3'b001 << grant_idx_s;
    end else begin
      req_ready = 3'b000;
    end
  end

  assign xfer_s = |(req_valid & req_ready);

  // Mux the granted requester's address and data.
  always_comb begin
    sel_addr_s = {ADDR_W{1'b0}};
    sel_data_s = {DATA_W{1'b0}};
    case (grant_idx_s)
      2'd1: begin
        sel_addr_s = req_addr[2*ADDR_W-1:ADDR_W];
        sel_data_s = req_data[2*DATA_W-1:DATA_W];
      end
      2'd2: begin
        sel_addr_s = req_addr[3*ADDR_W-1:2*ADDR_W];
        sel_data_s = req_data[3*DATA_W-1:2*DATA_W];
      end
      default: begin
        sel_addr_s = req_addr[ADDR_W-1:0];
        sel_data_s = req_data[DATA_W-1:0];
      end
    endcase
  end

  assign sel_nonzero_s = (sel_addr_s != {ADDR_W{1'b0}});

  // Rotating priority pointer and last-grant record.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ptr_r      <= 2'd0;
      last_grant <= 2'd0;
    end else if (xfer_s) begin
      ptr_r      <= ptr_after(grant_idx_s);
      last_grant <= grant_idx_s;
    end else begin
      ptr_r      <= ptr_r;
      last_grant <= last_grant;
    end
  end

  // Registered bank write port; writes to register 0 are accepted but dropped.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      reg_write    <= 1'b0;
      rd_addr      <= {ADDR_W{1'b0}};
      write_data   <= {DATA_W{1'b0}};
      pending_mask <= {NREG{1'b0}};
    end else if (xfer_s && sel_nonzero_s) begin
      reg_write    <= 1'b1;
      rd_addr      <= sel_addr_s;
      write_data   <= sel_data_s;
      pending_mask <= addr_onehot(sel_addr_s);
    end else begin
      reg_write    <= 1'b0;
      rd_addr      <= rd_addr;
      write_data   <= write_data;
      pending_mask <= {NREG{1'b0}};
    end
  end

  // Saturating write and drop statistics.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_count   <= 16'd0;
      drop_count <= 8'd0;
    end else if (xfer_s && sel_nonzero_s) begin
      wr_count   <= (wr_count == 16'hFFFF) ? wr_count : wr_count + 16'd1;
      drop_count <= drop_count;
    end else if (xfer_s) begin
      wr_count   <= wr_count;
      drop_count <= (drop_count == 8'hFF) ? drop_count : drop_count + 8'd1;
    end else begin
      wr_count   <= wr_count;
      drop_count <= drop_count;
    end
  end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Self-checking bench for reg_wr_arbiter: directed scenarios plus randomized
// traffic compared against a queue-free behavioural model of the arbitration rules.
`timescale 1ns/1ps

module tb_reg_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic [2:0]  req_valid;
  logic [11:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        reg_write;
  logic [3:0]  rd_addr;
  logic [31:0] write_data;
  logic [15:0] pending_mask;
  logic [1:0]  last_grant;
  logic [15:0] wr_count;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int          m_ptr;
  logic [1:0]  m_last;
  logic [15:0] m_wr;
  logic [7:0]  m_drop;
  logic        m_we;
  logic [3:0]  m_addr;
  logic [31:0] m_data;

  reg_wr_arbiter dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .reg_write(reg_write), .rd_addr(rd_addr),
    .write_data(write_data), .pending_mask(pending_mask),
    .last_grant(last_grant), .wr_count(wr_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_ptr = 0; m_last = 2'd0; m_wr = 16'd0; m_drop = 8'd0;
    m_we = 1'b0; m_addr = 4'd0; m_data = 32'd0;
  endtask

  // Index that wins this cycle, or -1 when nothing is granted.
  function automatic int model_grant(input logic [2:0] v, input logic h);
    model_grant = -1;
    if (!h) begin
      for (int k = 2; k >= 0; k--) begin
        if (v[(m_ptr + k) % 3]) model_grant = (m_ptr + k) % 3;
      end
    end
  endfunction

  function automatic logic [2:0] model_ready(input logic [2:0] v, input logic h);
    int g;
    g = model_grant(v, h);
    model_ready = (g < 0) ? 3'b000 : (3'b001 << g);
  endfunction

  // Apply the effect of one clock edge using the currently driven inputs.
  task automatic model_edge();
    int g;
    logic [3:0] a;
    g = model_grant(req_valid, hold);
    if (g >= 0) begin
      m_ptr  = (g + 1) % 3;
      m_last = 2'(g);
      a = req_addr[4*g +: 4];
      if (a != 4'd0) begin
        m_we = 1'b1; m_addr = a; m_data = req_data[32*g +: 32];
        if (m_wr != 16'hFFFF) m_wr = m_wr + 16'd1;
      end else begin
        m_we = 1'b0;
        if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
      end
    end else begin
      m_we = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1; hold = 1'b0; req_valid = 3'b000; req_addr = 12'd0; req_data = 96'd0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; hold = 1'b0; req_valid = 3'b111; req_addr = 12'h321; req_data = 96'd0;
    model_reset();
    #3;
    n_checks++;
    if ({reg_write, rd_addr, write_data, last_grant, wr_count, drop_count, pending_mask} !== 79'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b addr=%h data=%h lg=%0d wr=%0d drop=%0d mask=%h, want all zero",
               reg_write, rd_addr, write_data, last_grant, wr_count, drop_count, pending_mask);
    end
    do_reset();
    #1;
    n_checks++;
    if (req_ready !== 3'b000) begin
      n_fail++; $display("FAIL reset_ready: got %b want 000", req_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 3'b010; req_addr = 12'h050; req_data = {32'd0, 32'hDEADBEEF, 32'd0};
    #1;
    n_checks++;
    if (req_ready !== 3'b010) begin
      n_fail++; $display("FAIL single_ready: got %b want 010", req_ready);
    end
    @(posedge clk); model_edge(); #1;
    req_valid = 3'b000;
    n_checks++;
    if (reg_write !== 1'b1 || rd_addr !== 4'd5 || write_data !== 32'hDEADBEEF ||
        pending_mask !== 16'h0020 || wr_count !== 16'd1 || last_grant !== 2'd1) begin
      n_fail++;
      $display("FAIL single_out: got we=%b addr=%0d data=%h mask=%h wr=%0d lg=%0d want 1,5,deadbeef,0020,1,1",
               reg_write, rd_addr, write_data, pending_mask, wr_count, last_grant);
    end
    @(posedge clk); model_edge(); #1;
    n_checks++;
    if (reg_write !== 1'b0 || pending_mask !== 16'h0000 || rd_addr !== 4'd5) begin
      n_fail++; $display("FAIL single_idle: got we=%b mask=%h addr=%0d want 0,0000,5", reg_write, pending_mask, rd_addr);
    end
  endtask

  task automatic test_round_robin();
    int exp_g [6] = '{0, 1, 2, 0, 1, 2};
    do_reset();
    req_valid = 3'b111; req_addr = {4'd3, 4'd2, 4'd1};
    req_data = {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
    for (int k = 0; k < 6; k++) begin
      #1;
      n_checks++;
      if (req_ready !== (3'b001 << exp_g[k])) begin
        n_fail++; $display("FAIL rr_ready[%0d]: got %b want one-hot of %0d", k, req_ready, exp_g[k]);
      end
      @(posedge clk); model_edge(); #1;
      n_checks++;
      if (reg_write !== 1'b1 || rd_addr !== 4'(exp_g[k] + 1) || write_data !== req_data[32*exp_g[k] +: 32] ||
          last_grant !== 2'(exp_g[k])) begin
        n_fail++;
        $display("FAIL rr_out[%0d]: got we=%b addr=%0d data=%h lg=%0d want 1,%0d,%h,%0d",
                 k, reg_write, rd_addr, write_data, last_grant, exp_g[k] + 1, req_data[32*exp_g[k] +: 32], exp_g[k]);
      end
    end
    req_valid = 3'b000;
  endtask

  task automatic test_drop();
    logic [15:0] wr_before;
    wr_before = m_wr;
    req_valid = 3'b100; req_addr = 12'h000; req_data = {32'h00001234, 64'd0};
    #1;
    n_checks++;
    if (req_ready !== 3'b100) begin
      n_fail++; $display("FAIL drop_ready: got %b want 100", req_ready);
    end
    @(posedge clk); model_edge(); #1;
    req_valid = 3'b000;
    n_checks++;
    if (reg_write !== 1'b0 || pending_mask !== 16'd0 || drop_count !== 8'd1 || wr_count !== wr_before ||
        write_data === 32'h00001234) begin
      n_fail++;
      $display("FAIL drop_out: got we=%b mask=%h drop=%0d wr=%0d data=%h want 0,0000,1,%0d,not 1234",
               reg_write, pending_mask, drop_count, wr_count, write_data, wr_before);
    end
  endtask

  task automatic test_hold();
    int pre_ptr;
    req_valid = 3'b001; req_addr = 12'h009; req_data = 96'h1;
    @(posedge clk); model_edge(); #1;
    pre_ptr = m_ptr;
    req_valid = 3'b111; req_addr = 12'h456; hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (req_ready !== 3'b000) begin
        n_fail++; $display("FAIL hold_ready[%0d]: got %b want 000", k, req_ready);
      end
      @(posedge clk); model_edge(); #1;
      n_checks++;
      if (reg_write !== 1'b0 || pending_mask !== 16'd0) begin
        n_fail++; $display("FAIL hold_write[%0d]: got we=%b mask=%h want 0,0000", k, reg_write, pending_mask);
      end
    end
    hold = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== (3'b001 << pre_ptr)) begin
      n_fail++; $display("FAIL hold_resume: got %b want one-hot of %0d", req_ready, pre_ptr);
    end
    @(posedge clk); model_edge(); #1;
    req_valid = 3'b000;
  endtask

  task automatic test_async_reset();
    req_valid = 3'b001; req_addr = 12'h007; req_data = 96'h0000_0000_0000_0000_7777_7777; hold = 1'b0;
    #1;
    @(posedge clk); model_edge(); #1;
    n_checks++;
    if (reg_write !== 1'b1 || rd_addr !== 4'd7) begin
      n_fail++; $display("FAIL arst_setup: got we=%b addr=%0d want 1,7", reg_write, rd_addr);
    end
    req_valid = 3'b000;
    #2;
    rst_n = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (reg_write !== 1'b0 || rd_addr !== 4'd0 || write_data !== 32'd0 || wr_count !== 16'd0 ||
        drop_count !== 8'd0 || last_grant !== 2'd0 || pending_mask !== 16'd0) begin
      n_fail++;
      $display("FAIL arst_clear: got we=%b addr=%0d data=%h wr=%0d drop=%0d lg=%0d mask=%h want all zero",
               reg_write, rd_addr, write_data, wr_count, drop_count, last_grant, pending_mask);
    end
    @(posedge clk); #1;
    n_checks++;
    if (reg_write !== 1'b0) begin
      n_fail++; $display("FAIL arst_noedge: got we=%b want 0", reg_write);
    end
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++) begin
      req_valid = 3'($urandom_range(0, 7));
      hold      = ($urandom_range(0, 7) == 0);
      req_addr  = 12'($urandom);
      req_data  = {$urandom, $urandom, $urandom};
      #1;
      n_checks++;
      if (req_ready !== model_ready(req_valid, hold)) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", k, req_ready, model_ready(req_valid, hold));
      end
      @(posedge clk); model_edge(); #1;
      n_checks++;
      if (reg_write !== m_we || rd_addr !== m_addr || write_data !== m_data || last_grant !== m_last ||
          wr_count !== m_wr || drop_count !== m_drop || pending_mask !== (m_we ? (16'h0001 << m_addr) : 16'h0000)) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: got we=%b a=%0d d=%h lg=%0d wr=%0d dr=%0d mask=%h want %b,%0d,%h,%0d,%0d,%0d",
                 k, reg_write, rd_addr, write_data, last_grant, wr_count, drop_count, pending_mask,
                 m_we, m_addr, m_data, m_last, m_wr, m_drop);
      end
    end
    req_valid = 3'b000; hold = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    req_valid = 3'b001; req_addr = 12'h003; req_data = 96'h5A5A;
    for (int k = 0; k < 70000; k++) begin
      @(posedge clk); model_edge();
    end
    #1;
    n_checks++;
    if (wr_count !== 16'hFFFF || wr_count !== m_wr || drop_count !== 8'd0) begin
      n_fail++; $display("FAIL sat_wr: got wr=%h drop=%0d want ffff,0", wr_count, drop_count);
    end
    req_addr = 12'h000;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); model_edge();
    end
    #1;
    n_checks++;
    if (drop_count !== 8'hFF || drop_count !== m_drop || wr_count !== 16'hFFFF || reg_write !== 1'b0) begin
      n_fail++; $display("FAIL sat_drop: got drop=%h wr=%h we=%b want ff,ffff,0", drop_count, wr_count, reg_write);
    end
    req_valid = 3'b000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_drop();
    test_hold();
    test_random(400);
    test_async_reset();
    test_random(200);
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
